// File: rtl/pll_sweep_pkg.sv
// pll_sweep_pkg: mode encodings and sequencer state type shared by the delay sweeper.
package pll_sweep_pkg;
  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_SWEEP = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;
endpackage

// File: rtl/sweep_timer.sv
// sweep_timer: loadable down-counter, expired_o high while the count sits at zero.
module sweep_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/pll_delay_sweeper.sv
// pll_delay_sweeper: settle/dwell sequencer stepping SB_PLL40 DYNAMICDELAY codes.
// Define PLL_SWEEP_LED_EN to drive the debug led output.
module pll_delay_sweeper
  import pll_sweep_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int CODE_W = 4,
  parameter int CHANNEL_STEP = 0,
  parameter int DWELL_W = 24,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic [CODE_W-1:0]              start_code,
  input  logic [DWELL_W-1:0]             dwell,
  output logic [NUM_CHANNELS*CODE_W-1:0] delay_codes,
  output logic                           code_valid,
  output logic                           step_strobe,
  output logic                           sweep_wrap,
  output logic [7:0]                     led
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = DWELL_W > SW ? DWELL_W : SW;
  localparam int MAXC = 2 ** CODE_W - 1;
  state_t state_q;
  logic [CODE_W-1:0] base_q, base_d, pp_base;
  logic dir_q, dir_d, down, hold, expired, t_load;
  logic [TW-1:0] t_val;
  function automatic logic [NUM_CHANNELS*CODE_W-1:0] chan_codes(input logic [CODE_W-1:0] b);
    int s;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      s = int'(b) + k * CHANNEL_STEP;
      chan_codes[k*CODE_W +: CODE_W] = CODE_W'(s > MAXC ? MAXC : s);
    end
  endfunction
  // Ping-pong turns around at either end regardless of the stored direction.
  always_comb begin
    down = base_q == '1 ? 1'b1 : base_q == '0 ? 1'b0 : dir_q;
    pp_base = down ? base_q - 1'b1 : base_q + 1'b1;
    base_d = mode == MODE_PINGPONG ? pp_base : base_q + 1'b1;
    dir_d = mode == MODE_PINGPONG ? (pp_base == '1) | (down & (pp_base != '0)) : dir_q;
    hold = !(mode == MODE_SWEEP || mode == MODE_PINGPONG);
    t_load = enable & (state_q == IDLE | expired);
    t_val = (state_q == SETTLE || (state_q == DWELL && hold)) ? TW'(dwell) : TW'(SETTLE_CYCLES - 1);
  end
  sweep_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load_i   (t_load),
    .val_i    (t_val),
    .expired_o(expired)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      dir_q <= 1'b0;
      delay_codes <= '0;
      code_valid <= 1'b0;
      step_strobe <= 1'b0;
      sweep_wrap <= 1'b0;
    end else if (!enable) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      code_valid <= 1'b0;
      step_strobe <= 1'b0;
      sweep_wrap <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      sweep_wrap <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= SETTLE;
          base_q <= start_code;
          delay_codes <= chan_codes(start_code);
          step_strobe <= 1'b1;
        end
        SETTLE: if (expired) begin
          state_q <= DWELL;
          code_valid <= 1'b1;
        end
        DWELL: if (expired && !hold) begin
          state_q <= SETTLE;
          base_q <= base_d;
          dir_q <= dir_d;
          delay_codes <= chan_codes(base_d);
          step_strobe <= 1'b1;
          sweep_wrap <= base_d == '0;
          code_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
`ifdef PLL_SWEEP_LED_EN
  always_comb begin
    led = '0;
    led[CODE_W-1:0] = base_q;
    led[6] = dir_q;
    led[7] = code_valid;
  end
`else
  assign led = '0;
`endif
endmodule

// File: tb/tb_pll_delay_sweeper.sv
// tb_pll_delay_sweeper: randomized runs checked cycle by cycle against a code-schedule model.
module tb_pll_delay_sweeper;
  localparam int S = 4;
  logic clk = 1'b0;
  logic reset, enable;
  logic [1:0] mode;
  logic [3:0] start_code;
  logic [23:0] dwell;
  logic [7:0] codes0, codes5, led, led5;
  logic cv, ss, sw, cv5, ss5, sw5;
  int n_tests = 0, n_fail = 0;
  int seq[$];

  always #5 clk = ~clk;

  pll_delay_sweeper #(.NUM_CHANNELS(2), .CODE_W(4), .CHANNEL_STEP(0), .DWELL_W(24), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start_code(start_code), .dwell(dwell),
    .delay_codes(codes0), .code_valid(cv), .step_strobe(ss), .sweep_wrap(sw), .led(led));

  pll_delay_sweeper #(.NUM_CHANNELS(2), .CODE_W(4), .CHANNEL_STEP(5), .DWELL_W(24), .SETTLE_CYCLES(S)) dut5 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start_code(start_code), .dwell(dwell),
    .delay_codes(codes5), .code_valid(cv5), .step_strobe(ss5), .sweep_wrap(sw5), .led(led5));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Code visited at each step: wrap-around count-up, or a bounce between 0 and 15.
  function automatic void build_seq(input int m, input int s);
    int p;
    bit up;
    p = s;
    up = 1'b1;
    seq.delete();
    for (int i = 0; i < 64; i++) begin
      seq.push_back(p);
      if (m == 1) p = (p + 1) % 16;
      else if (m == 2) begin
        if (p == 15) up = 1'b0;
        else if (p == 0) up = 1'b1;
        p = up ? p + 1 : p - 1;
      end
    end
  endfunction

  task automatic run(input int m, input int s, input int dw, input int len);
    int per, i, ph, c, hi;
    bit stat;
    logic [3:0] c4, h4;
    build_seq(m, s);
    stat = (m == 0 || m == 3);
    per = S + dw + 1;
    mode = 2'(m);
    start_code = 4'(s);
    dwell = 24'(dw);
    enable = 1'b1;
    c = s;
    for (int t = 1; t <= len; t++) begin
      @(posedge clk);
      @(negedge clk);
      i = stat ? 0 : (t - 1) / per;
      ph = stat ? t - 1 : (t - 1) % per;
      c = seq[i];
      hi = c + 5 > 15 ? 15 : c + 5;
      c4 = 4'(c);
      h4 = 4'(hi);
      chk("step_strobe", {31'd0, ss}, stat ? {31'd0, t == 1} : {31'd0, ph == 0});
      chk("code_valid", {31'd0, cv}, {31'd0, ph >= S});
      chk("sweep_wrap", {31'd0, sw}, {31'd0, !stat && ph == 0 && i > 0 && c == 0});
      chk("delay_codes", {24'd0, codes0}, {24'd0, c4, c4});
      chk("sat_codes", {24'd0, codes5}, {24'd0, h4, c4});
      chk("led", {24'd0, led}, 32'd0);
      start_code = 4'($urandom);
    end
    enable = 1'b0;
    c4 = 4'(c);
    repeat ($urandom_range(1, 4)) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_valid", {31'd0, cv}, 32'd0);
      chk("idle_strobe", {31'd0, ss | sw}, 32'd0);
      chk("idle_codes", {24'd0, codes0}, {24'd0, c4, c4});
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    mode = 2'd1;
    start_code = 4'd9;
    dwell = 24'd2;
    repeat (3) begin
      @(negedge clk);
      chk("rst_codes", {24'd0, codes0}, 32'd0);
      chk("rst_flags", {29'd0, cv, ss, sw}, 32'd0);
      chk("rst_led", {24'd0, led}, 32'd0);
    end
    reset = 1'b0;
    run(1, 0, 2, 20);
    run(1, 14, 2, 30);
    run(2, 13, 2, 60);
    run(0, 9, 0, 40);
    run(3, 2, 1, 20);
    run(1, 12, 1, 15);
    run(1, 3, 1, 2);
    run(1, 7, 1, 10);
    mode = 2'd1;
    start_code = 4'd6;
    dwell = 24'd1;
    enable = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_codes", {24'd0, codes0}, 32'd0);
    chk("midrst_flags", {29'd0, cv, ss, sw}, 32'd0);
    reset = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_idle", {23'd0, cv, codes0}, 32'd0);
    repeat (30) run(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 5)), int'($urandom_range(1, 100)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
